shift_right_pipe: RTL and testbench
===================================

Name: shift_right_pipe

Overview:
- Pipelined 32-bit right shifter supporting logical (SRL) and arithmetic (SRA) modes.
- Complements the combinational left shifter in the ALU shift path.
- Two registered stages with valid/ready handshakes on both sides, so it can sit between the ALU operand latch and the writeback register, with backpressure.
- Shift amount is decomposed into 1/2/4/8/16 mux levels: stage 1 applies shamt[2:0], stage 2 applies shamt[4:3].

Parameters:
- WIDTH, 32, data width; must equal 2**SHAMT_W.
- SHAMT_W, 5, shift-amount width.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block accepts request this cycle.
- data_input  input  WIDTH  operand.
- ctrl_shiftamt  input  SHAMT_W  shift amount, 0..31.
- ctrl_mode  input  2  00 SRL, 01 SRA, 10 ROTR (see Optional Feature), 11 reserved (treated as SRL).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- data_srl  output  WIDTH  shifted result.

Behaviour:
- Reset (reset=0, asynchronous): s1_valid=0, s2_valid=0, so out_valid=0 and data_srl=0. in_ready is 1 once reset deasserts. Stage data registers clear to 0.
- Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Stage 1:
  - Capture on input transfer: data after shifts by shamt[0], shamt[1], shamt[2] (1, 2, 4); plus shamt[4:3] and mode.
  - Fill bits: 0 for SRL; data_input[WIDTH-1] for SRA; wrapped low bits for ROTR.
  - Sign bit is carried forward with the stage for SRA.
- Stage 2: applies shifts by 8 and 16 from stage-1 data with the same fill rule; drives data_srl, out_valid=s2_valid.
- Advance conditions:
  - s2 loads when !s2_valid || out_ready.
  - s1 advances to s2 under the same condition.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - Full throughput: one result per cycle with out_ready held high.
- Latency: result visible 2 cycles after the input transfer edge, i.e. out_valid rises at the second rising edge after acceptance.
- Stall: out_ready=0 with s2_valid=1 holds data_srl stable. s1 holds; when s1 is full, in_ready=0. Maximum 2 requests in flight; no loss, no duplication, in-order.
- Simultaneous: an output transfer and an input transfer in the same cycle with both stages full shifts everything forward in one edge.
- shamt=0: output equals input for all modes.
- shamt=31:
  - SRL yields input[31].
  - SRA yields all sign bits.
  - ROTR yields {input[30:0], input[31]}.
- Reset mid-operation drops all in-flight requests; no output transfer for them.
- Inputs are sampled only on an input transfer; changes while in_ready=0 are ignored.

Optional Feature:
- Macro SHIFT_ROTR_EN.
- Defined: mode 10 performs rotate-right (bits shifted out of LSB re-enter at MSB at each mux level).
- Undefined: mode 10 behaves as SRL and no rotate muxing is synthesized.

Decomposition:
- Shared package/header: mode encodings SHIFT_MODE_SRL=2'b00, SHIFT_MODE_SRA=2'b01, SHIFT_MODE_ROTR=2'b10; WIDTH/SHAMT_W defaults.
- Sub-module rshift_level (natural):
  - Parameter DIST.
  - Inputs: data, enable bit, mode, sign.
  - Output: shifted data.
  - Instanced 3× in stage 1 (DIST 1, 2, 4) and 2× in stage 2 (DIST 8, 16).
- Pipeline registers and handshake logic live in the top.

Test Plan:
- SRA 0x80000000, shamt 4 -> data_srl=0xF8000000, out_valid asserted 2 cycles after acceptance.
- SRL 0x80000000, shamt 31 -> 0x00000001. SRL 0xDEADBEEF, shamt 0 -> 0xDEADBEEF. SRA 0x7FFFFFFF, shamt 31 -> 0x00000000.
- With SHIFT_ROTR_EN: ROTR 0x00000001, shamt 1 -> 0x80000000; ROTR 0x12345678, shamt 16 -> 0x56781234. Without it: mode 10 on 0x00000001, shamt 1 -> 0x00000000.
- Backpressure: out_ready=0, offer 3 requests (0x10>>1, 0x20>>2, 0x40>>3 SRL) -> 2 accepted, in_ready=0 for the third; raise out_ready -> results 0x8, 0x8, 0x8 in order with no gaps or duplicates.
- Streaming: 16 back-to-back requests with out_ready=1 -> 16 results on consecutive cycles, in_ready constantly 1.
- Reset pulled low with 2 requests in flight -> out_valid=0 and data_srl=0 immediately (asynchronous); after release, no stale results emerge.

Source files
------------

// File: rtl/shift_right_pipe_pkg.sv
// Shared definitions for the pipelined right shifter: default sizes,
// shift-mode encodings and the mode decoder used at the pipe input.
// Optional feature macro: SHIFT_ROTR_EN (enables rotate-right for mode 2'b10).
package shift_right_pipe_pkg;

   localparam int RSP_WIDTH   = 32;
   localparam int RSP_SHAMT_W = 5;

   typedef enum logic [1:0] {
      SHIFT_MODE_SRL  = 2'b00,
      SHIFT_MODE_SRA  = 2'b01,
      SHIFT_MODE_ROTR = 2'b10
   } shift_mode_e;

   // Reserved encodings, and rotate when it is not built in, fall back to SRL.
   function automatic shift_mode_e decode_mode(input logic [1:0] raw);
      shift_mode_e m;
      case (raw)
         2'b01:   m = SHIFT_MODE_SRA;
`ifdef SHIFT_ROTR_EN
         2'b10:   m = SHIFT_MODE_ROTR;
`endif
         default: m = SHIFT_MODE_SRL;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/shift_right_pipe_rshift_level.sv
// One fixed-distance level of the right-shift mux tree. When enabled the
// word moves right by DIST and the vacated top bits take the mode's fill:
// zeros for SRL, the carried sign for SRA, the wrapped low bits for ROTR.
// Optional feature macro: SHIFT_ROTR_EN.
module rshift_level
   import shift_right_pipe_pkg::*;
#(
   parameter int WIDTH = RSP_WIDTH,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] data,
   input  logic             enable,
   input  shift_mode_e      mode,
   input  logic             sign,
   output logic [WIDTH-1:0] shifted
);

   logic [DIST-1:0] fill;

   // Select the fill bits for this mode, then apply the shift if enabled.
   always_comb begin
      fill = '0;
      case (mode)
         SHIFT_MODE_SRA:  fill = {DIST{sign}};
`ifdef SHIFT_ROTR_EN
         SHIFT_MODE_ROTR: fill = data[DIST-1:0];
`endif
         default:         fill = '0;
      endcase
      shifted = enable ? {fill, data[WIDTH-1:DIST]} : data;
   end

endmodule

// File: rtl/shift_right_pipe.sv
// Two-stage pipelined 32-bit right shifter (SRL/SRA, optional ROTR) with
// valid/ready handshakes on both sides. Stage 1 applies shamt[2:0]
// (1/2/4), stage 2 applies shamt[4:3] (8/16).
// Optional feature macro: SHIFT_ROTR_EN.
module shift_right_pipe
   import shift_right_pipe_pkg::*;
#(
   parameter int WIDTH   = RSP_WIDTH,
   parameter int SHAMT_W = RSP_SHAMT_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   data_input,
   input  logic [SHAMT_W-1:0] ctrl_shiftamt,
   input  logic [1:0]         ctrl_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   data_srl
);

   shift_mode_e      in_mode;
   logic             in_sign;
   logic [WIDTH-1:0] lvl1_data;
   logic [WIDTH-1:0] lvl2_data;
   logic [WIDTH-1:0] lvl4_data;
   logic [WIDTH-1:0] lvl8_data;
   logic [WIDTH-1:0] lvl16_data;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;
   logic [1:0]       s1_hi_shamt;
   shift_mode_e      s1_mode;
   logic             s1_sign;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_data;

   logic             advance;

   assign in_mode = decode_mode(ctrl_mode);
   assign in_sign = data_input[WIDTH-1];

   // Stage 2 can take new data when it is empty or its result is leaving;
   // stage 1 can accept when it is empty or it is moving into stage 2.
   assign advance   = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || advance;
   assign out_valid = s2_valid;
   assign data_srl  = s2_data;

   rshift_level #(.WIDTH(WIDTH), .DIST(1)) u_lvl1 (
      .data(data_input), .enable(ctrl_shiftamt[0]), .mode(in_mode),
      .sign(in_sign), .shifted(lvl1_data)
   );
   rshift_level #(.WIDTH(WIDTH), .DIST(2)) u_lvl2 (
      .data(lvl1_data), .enable(ctrl_shiftamt[1]), .mode(in_mode),
      .sign(in_sign), .shifted(lvl2_data)
   );
   rshift_level #(.WIDTH(WIDTH), .DIST(4)) u_lvl4 (
      .data(lvl2_data), .enable(ctrl_shiftamt[2]), .mode(in_mode),
      .sign(in_sign), .shifted(lvl4_data)
   );
   rshift_level #(.WIDTH(WIDTH), .DIST(8)) u_lvl8 (
      .data(s1_data), .enable(s1_hi_shamt[0]), .mode(s1_mode),
      .sign(s1_sign), .shifted(lvl8_data)
   );
   rshift_level #(.WIDTH(WIDTH), .DIST(16)) u_lvl16 (
      .data(lvl8_data), .enable(s1_hi_shamt[1]), .mode(s1_mode),
      .sign(s1_sign), .shifted(lvl16_data)
   );

   // Stage 1 register: capture the partially shifted operand, the remaining
   // shift bits, the mode and the sign whenever the input side can move.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_valid    <= 1'b0;
         s1_data     <= '0;
         s1_hi_shamt <= 2'b00;
         s1_mode     <= SHIFT_MODE_SRL;
         s1_sign     <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data     <= lvl4_data;
            s1_hi_shamt <= ctrl_shiftamt[4:3];
            s1_mode     <= in_mode;
            s1_sign     <= in_sign;
         end
      end
   end

   // Stage 2 register: finish the shift and hold the result until consumed.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= lvl16_data;
         end
      end
   end

endmodule

// File: tb/tb_shift_right_pipe.sv
// Self-checking bench for shift_right_pipe: directed vectors with literal
// expectations plus a scoreboard driven by an arithmetic model of the shift.
// Honours SHIFT_ROTR_EN the same way the design does.
module tb_shift_right_pipe;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_input;
   logic [4:0]  ctrl_shiftamt;
   logic [1:0]  ctrl_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_srl;

   int vectors;
   int miscompares;
   int out_count;

   logic [31:0] exp_q[$];
   logic        stall_prev;
   logic [31:0] stall_data;

   shift_right_pipe dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .data_input(data_input), .ctrl_shiftamt(ctrl_shiftamt),
      .ctrl_mode(ctrl_mode), .out_valid(out_valid), .out_ready(out_ready),
      .data_srl(data_srl)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference shift computed directly from the mode's definition.
   function automatic logic [31:0] model_shift(input logic [31:0] x, input int s,
                                               input logic [1:0] m);
      logic signed [31:0] sx;
      sx = x;
      case (m)
         2'b01: return sx >>> s;
`ifdef SHIFT_ROTR_EN
         2'b10: return (s == 0) ? x : ((x >> s) | (x << (32 - s)));
`endif
         default: return x >> s;
      endcase
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, required %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Scoreboard: every output transfer must match the oldest accepted request,
   // and a stalled result must not change.
   always @(negedge clock) begin
      if (!reset) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev && out_valid)
            check_output("stall_hold", data_srl, stall_data);
         if (out_valid && out_ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_output: got %h, required no output", data_srl);
            end else begin
               check_output("model", data_srl, exp_q.pop_front());
            end
         end
         stall_prev = out_valid && !out_ready;
         stall_data = data_srl;
         if (in_valid && in_ready)
            exp_q.push_back(model_shift(data_input, int'(ctrl_shiftamt), ctrl_mode));
      end
   end

   // Offer one request and wait (bounded) until it is accepted.
   task automatic apply_stimulus(input logic [31:0] d, input logic [4:0] s,
                                 input logic [1:0] m);
      bit accepted;
      accepted = 1'b0;
      data_input = d;
      ctrl_shiftamt = s;
      ctrl_mode = m;
      in_valid = 1'b1;
      for (int n = 0; n < 20 && !accepted; n++) begin
         @(negedge clock);
         accepted = in_ready;
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      if (!accepted) check_output("accept_timeout", 32'd0, 32'd1);
   endtask

   // Single request through an empty pipe: checks latency and the literal result.
   task automatic run_single(input string name, input logic [31:0] d,
                             input logic [4:0] s, input logic [1:0] m,
                             input logic [31:0] expected);
      apply_stimulus(d, s, m);
      check_output({name, "_valid_edge1"}, 32'(out_valid), 32'd0);
      @(posedge clock);
      #1;
      check_output({name, "_valid_edge2"}, 32'(out_valid), 32'd1);
      check_output(name, data_srl, expected);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vectors = 0;
      miscompares = 0;
      out_count = 0;
      reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      data_input = '0;
      ctrl_shiftamt = '0;
      ctrl_mode = 2'b00;

      #1;
      check_output("reset_out_valid", 32'(out_valid), 32'd0);
      check_output("reset_data_srl", data_srl, 32'd0);
      #21;
      reset = 1'b1;
      #1;
      check_output("reset_in_ready", 32'(in_ready), 32'd1);
      @(posedge clock);
      #1;

      // Directed single-shot vectors.
      run_single("sra_80000000_4",  32'h80000000, 5'd4,  2'b01, 32'hF8000000);
      run_single("srl_80000000_31", 32'h80000000, 5'd31, 2'b00, 32'h00000001);
      run_single("srl_deadbeef_0",  32'hDEADBEEF, 5'd0,  2'b00, 32'hDEADBEEF);
      run_single("sra_7fffffff_31", 32'h7FFFFFFF, 5'd31, 2'b01, 32'h00000000);
      run_single("sra_80000000_31", 32'h80000000, 5'd31, 2'b01, 32'hFFFFFFFF);
      run_single("sra_80000000_0",  32'h80000000, 5'd0,  2'b01, 32'h80000000);
      run_single("sra_c3000000_9",  32'hC3000000, 5'd9,  2'b01, 32'hFFE18000);
      run_single("rsvd_f0000000_4", 32'hF0000000, 5'd4,  2'b11, 32'h0F000000);
`ifdef SHIFT_ROTR_EN
      run_single("rotr_00000001_1",  32'h00000001, 5'd1,  2'b10, 32'h80000000);
      run_single("rotr_12345678_16", 32'h12345678, 5'd16, 2'b10, 32'h56781234);
      run_single("rotr_80000001_31", 32'h80000001, 5'd31, 2'b10, 32'h00000003);
      run_single("rotr_abcdef01_0",  32'hABCDEF01, 5'd0,  2'b10, 32'hABCDEF01);
`else
      run_single("mode10_00000001_1",  32'h00000001, 5'd1,  2'b10, 32'h00000000);
      run_single("mode10_80000000_31", 32'h80000000, 5'd31, 2'b10, 32'h00000001);
`endif

      // Backpressure: two requests fill the pipe, the third must wait.
      out_ready = 1'b0;
      in_valid = 1'b1;
      ctrl_mode = 2'b00;
      data_input = 32'h10; ctrl_shiftamt = 5'd1;
      @(negedge clock);
      check_output("bp_ready_req1", 32'(in_ready), 32'd1);
      @(posedge clock); #1;
      data_input = 32'h20; ctrl_shiftamt = 5'd2;
      @(negedge clock);
      check_output("bp_ready_req2", 32'(in_ready), 32'd1);
      @(posedge clock); #1;
      data_input = 32'h40; ctrl_shiftamt = 5'd3;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         check_output("bp_ready_full", 32'(in_ready), 32'd0);
         check_output("bp_hold_data", data_srl, 32'h8);
         @(posedge clock); #1;
         // Garbage on the input while stalled must be ignored.
         data_input = (k == 1) ? 32'hFFFFFFFF : 32'h40;
         ctrl_shiftamt = (k == 1) ? 5'd0 : 5'd3;
      end
      out_ready = 1'b1;
      @(negedge clock);
      check_output("bp_ready_release", 32'(in_ready), 32'd1);
      check_output("bp_out1_valid", 32'(out_valid), 32'd1);
      check_output("bp_out1", data_srl, 32'h8);
      @(posedge clock); #1;
      in_valid = 1'b0;
      @(negedge clock);
      check_output("bp_out2_valid", 32'(out_valid), 32'd1);
      check_output("bp_out2", data_srl, 32'h8);
      @(posedge clock);
      @(negedge clock);
      check_output("bp_out3_valid", 32'(out_valid), 32'd1);
      check_output("bp_out3", data_srl, 32'h8);
      @(posedge clock);
      @(negedge clock);
      check_output("bp_drained", 32'(out_valid), 32'd0);
      @(posedge clock); #1;

      // Streaming: 16 back-to-back requests, one result per cycle.
      out_count = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         data_input = 32'(32'h9E3779B9 * 32'(i + 1));
         ctrl_shiftamt = 5'((i * 7) % 32);
         ctrl_mode = 2'(i % 4);
         @(negedge clock);
         check_output("stream_in_ready", 32'(in_ready), 32'd1);
         check_output("stream_out_valid", 32'(out_valid), (i >= 2) ? 32'd1 : 32'd0);
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         check_output("stream_tail_valid", 32'(out_valid), 32'd1);
         @(posedge clock); #1;
      end
      @(negedge clock);
      check_output("stream_done", 32'(out_valid), 32'd0);
      check_output("stream_count", 32'(out_count), 32'd16);
      @(posedge clock); #1;

      // Reset with two requests in flight drops them immediately.
      out_ready = 1'b0;
      apply_stimulus(32'hAAAA5555, 5'd3, 2'b01);
      apply_stimulus(32'h12345678, 5'd8, 2'b00);
      check_output("rst_inflight_valid", 32'(out_valid), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check_output("rst_async_valid", 32'(out_valid), 32'd0);
      check_output("rst_async_data", data_srl, 32'd0);
      @(negedge clock);
      @(posedge clock); #1;
      reset = 1'b1;
      out_ready = 1'b1;
      out_count = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check_output("rst_no_stale", 32'(out_valid), 32'd0);
      end
      check_output("rst_out_count", 32'(out_count), 32'd0);
      check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
